// File: rtl/wc_pkg.sv
// Shared constants and state type for the Winograd tile feeder and its sub-blocks.
package wc_pkg;
    localparam int W      = 10;     // sample width
    localparam int N      = 7;      // window length, m+r-1 for F(3,5)
    localparam int S      = 3;      // window stride, outputs per WC tile
    localparam int DW     = W * N;  // width of the WC D input
    localparam int NEED_W = 3;      // width of the samples-needed counter

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_PAD = 1'b1
    } wc_state_e;
endpackage

// File: rtl/wc_tap_shreg.sv
// N-entry tap shift register: new sample enters slot N-1, slot 0 holds the oldest.
module wc_tap_shreg #(
    parameter int W = 10,
    parameter int N = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           shift_en_i,
    input  logic           clear_i,
    input  logic [W-1:0]   din_i,
    output logic [W*N-1:0] shifted_o
);
    logic [W*N-1:0] taps_q, taps_d;

    // Value the register takes on a shift; the feeder captures it as the window.
    assign shifted_o = {din_i, taps_q[W*N-1:W]};

    always_comb begin
        taps_d = taps_q;
        if (clear_i) begin
            taps_d = '0;
        end else if (shift_en_i) begin
            taps_d = shifted_o;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            taps_q <= '0;
        end else begin
            taps_q <= taps_d;
        end
    end
endmodule

// File: rtl/wc_tile_feeder.sv
// Slides an N-sample window with stride S over each input row and hands windows to the WC stage.
// Handshake: a transfer happens on a cycle where valid and ready are both 1; valid never depends on ready.
module wc_tile_feeder
    import wc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_d,
    output logic              out_last,
    output wc_state_e         dbg_state_o
);
    localparam logic [NEED_W-1:0] NEED_FULL   = NEED_W'(N);
    localparam logic [NEED_W-1:0] NEED_STRIDE = NEED_W'(S);
    localparam logic [NEED_W-1:0] NEED_ONE    = NEED_W'(1);

    wc_state_e         state_q, state_d;
    logic [NEED_W-1:0] need_q, need_d;
    logic [DW-1:0]     win_q, win_d;
    logic              ov_q, ov_d;
    logic              last_q, last_d;
    logic              live_q;
    logic              free, accept, last_step, shift_en, clear;
    logic [W-1:0]      sh_din;
    logic [DW-1:0]     shifted;

    // Padding shifts zeros; kept outside the FSM block so the shifted value has no feedback path.
    assign sh_din = (state_q == ST_PAD) ? '0 : in_data;

    wc_tap_shreg #(.W(W), .N(N)) u_shreg (
        .clk        (clk),
        .rst        (rst),
        .shift_en_i (shift_en),
        .clear_i    (clear),
        .din_i      (sh_din),
        .shifted_o  (shifted)
    );

    assign free      = !ov_q || out_ready;
    assign in_ready  = live_q && (state_q == ST_RUN) && free;
    assign accept    = in_valid && in_ready;
    assign last_step = (need_q == NEED_ONE);

    always_comb begin
        state_d  = state_q;
        need_d   = need_q;
        win_d    = win_q;
        last_d   = last_q;
        ov_d     = ov_q && !out_ready;
        shift_en = 1'b0;
        clear    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    shift_en = 1'b1;
                    if (last_step) begin
                        ov_d   = 1'b1;
                        win_d  = shifted;
                        last_d = in_last;
                        need_d = in_last ? NEED_FULL : NEED_STRIDE;
                        clear  = in_last;
                    end else begin
                        need_d = need_q - NEED_ONE;
                        if (in_last) begin
                            state_d = ST_PAD;
                        end
                    end
                end
            end
            ST_PAD: begin
                if (free) begin
                    shift_en = 1'b1;
                    if (last_step) begin
                        ov_d    = 1'b1;
                        win_d   = shifted;
                        last_d  = 1'b1;
                        need_d  = NEED_FULL;
                        clear   = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        need_d = need_q - NEED_ONE;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // live_q holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            need_q  <= NEED_FULL;
            win_q   <= '0;
            ov_q    <= 1'b0;
            last_q  <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            need_q  <= need_d;
            win_q   <= win_d;
            ov_q    <= ov_d;
            last_q  <= last_d;
            live_q  <= 1'b1;
        end
    end

    assign out_valid   = ov_q;
    assign out_d       = win_q;
    assign out_last    = last_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_wc_tile_feeder.sv
// Bench for wc_tile_feeder: directed cycle table, hand sequences, and a random row stream vs a window model.
module tb_wc_tile_feeder;
    import wc_pkg::*;

    localparam int ROWS   = 1000;
    localparam int BUDGET = 80000;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_d;
    logic          out_last;
    wc_state_e     dbg_state;

    always #5 clk = ~clk;

    wc_tile_feeder dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_d       (out_d),
        .out_last    (out_last),
        .dbg_state_o (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic          iv;
        logic [W-1:0]  data;
        logic          il;
        logic          ordy;
        logic          e_ov;
        logic          e_ol;
        logic          e_ir;
        logic [DW-1:0] e_d;
    } vec_t;

    vec_t          vecs[$];
    logic [W-1:0]  row_buf[$];
    logic [DW:0]   exp_q[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] mk_win(input int base, input int cnt);
        logic [DW-1:0] w;
        w = '0;
        for (int j = 0; j < N; j++) begin
            w[W*j +: W] = (j < cnt) ? W'(base + j) : '0;
        end
        return w;
    endfunction

    function automatic int wcount(input int len);
        return (len <= N) ? 1 : ((len - N + S - 1) / S) + 1;
    endfunction

    task automatic push_win(input int start, input logic last);
        logic [DW-1:0] w;
        int k;
        k = row_buf.size();
        w = '0;
        for (int j = 0; j < N; j++) begin
            if (start + j < k) w[W*j +: W] = row_buf[start + j];
        end
        exp_q.push_back({last, w});
    endtask

    // Windows start at sample offsets 0, S, 2S, ...; the final one is zero-filled past the row end.
    task automatic model_accept(input logic [W-1:0] d, input logic last);
        int k;
        row_buf.push_back(d);
        k = row_buf.size();
        if (k >= N && ((k - N) % S) == 0) begin
            push_win(k - N, last);
        end else if (last) begin
            push_win((wcount(k) - 1) * S, 1'b1);
        end
        if (last) row_buf.delete();
    endtask

    task automatic add_vec(input logic iv, input int data, input logic il, input logic ordy,
                           input logic e_ov, input logic e_ol, input logic e_ir, input logic [DW-1:0] e_d);
        vec_t v;
        v.iv = iv; v.data = W'(data); v.il = il; v.ordy = ordy;
        v.e_ov = e_ov; v.e_ol = e_ol; v.e_ir = e_ir; v.e_d = e_d;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) step();
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_out_last", out_last, 1'b0);
        chk("rst_out_d", out_d, '0);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_state", dbg_state, ST_RUN);
        rst = 1'b1;
        step();
        chk1("post_rst_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        int rows_done, pos, len, cyc, got_win, exp_win;
        logic acc;
        logic [DW:0] e;

        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        #2;
        do_reset();

        // Row 1..10 (window at 7, final window at 10 with no pad), then row 1..5 padded.
        for (int i = 1; i <= 6; i++) add_vec(1, i, 0, 1, 0, 0, 1, '0);
        add_vec(1, 7, 0, 1, 1, 0, 1, mk_win(1, 7));
        add_vec(1, 8, 0, 1, 0, 0, 1, '0);
        add_vec(1, 9, 0, 1, 0, 0, 1, '0);
        add_vec(1, 10, 1, 1, 1, 1, 1, mk_win(4, 7));
        add_vec(0, 0, 0, 1, 0, 0, 1, '0);
        for (int i = 1; i <= 4; i++) add_vec(1, i, 0, 1, 0, 0, 1, '0);
        add_vec(1, 5, 1, 1, 0, 0, 0, '0);
        add_vec(0, 0, 0, 1, 0, 0, 0, '0);
        add_vec(0, 0, 0, 1, 1, 1, 1, mk_win(1, 5));
        add_vec(0, 0, 0, 1, 0, 0, 1, '0);

        for (int i = 0; i < vecs.size(); i++) begin
            in_valid = vecs[i].iv; in_data = vecs[i].data;
            in_last = vecs[i].il; out_ready = vecs[i].ordy;
            step();
            chk1($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
            chk1($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_ir);
            if (vecs[i].e_ov) begin
                chk($sformatf("vec%0d_out_d", i), out_d, vecs[i].e_d);
                chk1($sformatf("vec%0d_out_last", i), out_last, vecs[i].e_ol);
            end
        end

        // Backpressure: window held for 5 cycles, pending sample 8 must not be lost.
        in_last = 1'b0; out_ready = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            in_valid = 1'b1; in_data = W'(i);
            step();
        end
        in_data = W'(8); out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk1($sformatf("hold%0d_out_valid", c), out_valid, 1'b1);
            chk($sformatf("hold%0d_out_d", c), out_d, mk_win(1, 7));
            chk1($sformatf("hold%0d_in_ready", c), in_ready, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        chk1("release_in_ready", in_ready, 1'b1);
        step();
        chk1("release_out_valid", out_valid, 1'b0);
        in_data = W'(9); step();
        in_data = W'(10); in_last = 1'b1; step();
        chk1("hold_end_out_valid", out_valid, 1'b1);
        chk1("hold_end_out_last", out_last, 1'b1);
        chk("hold_end_out_d", out_d, mk_win(4, 7));
        in_valid = 1'b0; in_last = 1'b0;
        step();
        chk1("hold_end_consumed", out_valid, 1'b0);

        // Reset asserted during the padding of a 4-sample row.
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = W'(i); in_last = (i == 4);
            step();
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk1("pad_state", dbg_state, ST_PAD);
        chk1("pad_in_ready", in_ready, 1'b0);
        step();
        rst = 1'b0;
        #1;
        chk1("midpad_rst_out_valid", out_valid, 1'b0);
        chk1("midpad_rst_out_last", out_last, 1'b0);
        chk("midpad_rst_out_d", out_d, '0);
        chk1("midpad_rst_in_ready", in_ready, 1'b0);
        chk1("midpad_rst_state", dbg_state, ST_RUN);
        step(); step();
        rst = 1'b1;
        step();
        for (int i = 11; i <= 17; i++) begin
            in_valid = 1'b1; in_data = W'(i);
            step();
            if (i < 17) chk1($sformatf("after_rst_s%0d_out_valid", i), out_valid, 1'b0);
        end
        in_valid = 1'b0;
        chk1("after_rst_out_valid", out_valid, 1'b1);
        chk("after_rst_out_d", out_d, mk_win(11, 7));
        chk1("after_rst_out_last", out_last, 1'b0);
        step();
        chk1("after_rst_consumed", out_valid, 1'b0);

        // Random rows against the window model.
        do_reset();
        row_buf.delete();
        exp_q.delete();
        rows_done = 0; pos = 0; cyc = 0; got_win = 0;
        len = $urandom_range(1, 40);
        exp_win = wcount(len);
        while (cyc < BUDGET && !(rows_done == ROWS && exp_q.size() == 0 && !out_valid)) begin
            if (!in_valid && rows_done < ROWS && $urandom_range(0, 7) != 0) begin
                in_valid = 1'b1;
                in_data  = W'($urandom);
                in_last  = (pos == len - 1);
            end
            out_ready = ($urandom_range(0, 7) != 0);
            @(negedge clk);
            if (out_valid && out_ready) begin
                got_win++;
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL rand_extra_window: got %h want no window", out_d);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("rand_win%0d_d", got_win), out_d, e[DW-1:0]);
                    chk1($sformatf("rand_win%0d_last", got_win), out_last, e[DW]);
                end
            end
            acc = in_valid && in_ready;
            if (acc) begin
                model_accept(in_data, in_last);
                if (in_last) begin
                    rows_done++;
                    pos = 0;
                    if (rows_done < ROWS) begin
                        len = $urandom_range(1, 40);
                        exp_win += wcount(len);
                    end
                end else begin
                    pos++;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            if (acc) in_valid = 1'b0;
        end
        n_tests++;
        if (cyc >= BUDGET) begin
            n_fail++;
            $display("FAIL rand_timeout: got %0d cycles want below %0d", cyc, BUDGET);
        end
        chk("rand_rows_done", DW'(rows_done), DW'(ROWS));
        chk("rand_window_count", DW'(got_win), DW'(exp_win));
        chk("rand_leftover", DW'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
